// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_dispatch stream dispatcher.
//   DEMUX_WIDTH  default beat width
//   DEMUX_CNT_W  default width of each delivered-beat counter
//   dispatch_mode_e  target selection policy (explicit select / round-robin)
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_CNT_W = 8;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } dispatch_mode_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with valid/ready handshake and a
// wrapping delivered-beat counter.
//   clk, rst_n  clock, synchronous active-low reset
//   acc         load in_data into the slot this cycle
//   in_data     payload to load
//   ready       consumer ready
//   data, valid registered payload and occupancy
//   free        slot can take a beat this cycle (empty or draining)
//   cnt         beats delivered (valid && ready), wrapping
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             hs;

  assign hs   = vld_p1 && ready;
  // A draining slot can be refilled in the same cycle, so a ready consumer
  // keeps the slot free even while it is full.
  assign free = !vld_p1 || ready;

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      if (acc) begin
        data_p1 <= in_data;
        vld_p1  <= 1'b1;
      end else if (hs) begin
        vld_p1  <= 1'b0;
      end
      if (hs) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  assign data  = data_p1;
  assign valid = vld_p1;
  assign cnt   = cnt_p1;

endmodule

// File: rtl/demux_dispatch.sv
// demux_dispatch: 1-to-2 stream dispatcher with per-output one-entry buffers.
// Each accepted beat goes to output sel (mode=0) or to the round-robin
// pointer rr_ptr (mode=1). in_ready depends only on the target slot.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_data/in_valid/in_ready  input stream
//   mode, sel                  target policy and explicit target
//   outN_data/valid/ready      output streams (N = 0, 1)
//   rr_ptr                     next round-robin target
//   cnt0, cnt1                 delivered-beat counters, wrapping
module demux_dispatch
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             sel,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             rr_ptr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic           tgt_p0;
  logic           acc_p0;
  logic           free0;
  logic           free1;
  logic           rr_p1;
  dispatch_mode_e mode_e;

  // ---- stage p0: target selection and accept ----
  assign mode_e   = dispatch_mode_e'(mode);
  assign tgt_p0   = (mode_e == MODE_RR) ? rr_p1 : sel;
  assign in_ready = tgt_p0 ? free1 : free0;
  assign acc_p0   = in_valid && in_ready;

  // ---- stage p1: round-robin pointer ----
  // Advances only on an accepted beat, so a stalled target keeps its turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_p1 <= 1'b0;
    end else if (acc_p0 && (mode_e == MODE_RR)) begin
      rr_p1 <= ~rr_p1;
    end
  end

  assign rr_ptr = rr_p1;

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc     (acc_p0 && !tgt_p0),
    .in_data (in_data),
    .ready   (out0_ready),
    .data    (out0_data),
    .valid   (out0_valid),
    .free    (free0),
    .cnt     (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc     (acc_p0 && tgt_p0),
    .in_data (in_data),
    .ready   (out1_ready),
    .data    (out1_data),
    .valid   (out1_valid),
    .free    (free1),
    .cnt     (cnt1)
  );

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: directed scenarios followed by
// randomized traffic, checked by a queue-based scoreboard.
module tb_demux_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic       sel;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
  logic       rr_ptr;
  logic [7:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: beats accepted but not yet delivered per output,
  // the round-robin turn and delivered totals.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       rr_m    = 1'b0;
  int         cnt0_m  = 0;
  int         cnt1_m  = 0;
  bit         started = 1'b0;
  logic       p_tgt, m_tgt, m_ir;

  always #5 clk = ~clk;

  demux_dispatch #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .sel        (sel),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .rr_ptr     (rr_ptr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: at each edge, a beat offered to a target
  // whose pending list is empty is accepted and queued for that output.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      rr_m    = 1'b0;
      cnt0_m  = 0;
      cnt1_m  = 0;
      started = 1'b1;
    end else if (started && in_valid) begin
      p_tgt = mode ? rr_m : sel;
      if (p_tgt == 1'b0 && q0.size() == 0) begin
        q0.push_back(in_data);
        if (mode) rr_m = ~rr_m;
      end else if (p_tgt == 1'b1 && q1.size() == 0) begin
        q1.push_back(in_data);
        if (mode) rr_m = ~rr_m;
      end
    end
  end

  // Monitor: compares DUT outputs with the model mid-cycle and retires
  // beats that the consumer takes at the coming edge.
  always @(negedge clk) begin
    if (started) begin
      m_tgt = mode ? rr_m : sel;
      m_ir  = m_tgt ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
      check("rr_ptr", {31'd0, rr_ptr}, {31'd0, rr_m});
      check("cnt0", {24'd0, cnt0}, 32'(cnt0_m % 256));
      check("cnt1", {24'd0, cnt1}, 32'(cnt1_m % 256));
      check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
      check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) check("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
      if (q1.size() != 0) check("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
      if (rst_n) begin
        if (q0.size() != 0 && out0_ready) begin
          void'(q0.pop_front());
          cnt0_m++;
        end
        if (q1.size() != 0 && out1_ready) begin
          void'(q1.pop_front());
          cnt1_m++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'hEE; in_valid = 1'b1; mode = 1'b0; sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset with a beat offered: nothing may be captured.
    do_reset(2);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out0_data", {24'd0, out0_data}, 32'd0);
    check("rst_rr_ptr", {31'd0, rr_ptr}, 32'd0);
    check("rst_cnt0", {24'd0, cnt0}, 32'd0);
    in_valid = 1'b0;
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Explicit select.
    in_valid = 1'b1; in_data = 8'hA1; sel = 1'b0;
    tick();
    check("sel_out0_data", {24'd0, out0_data}, 32'hA1);
    check("sel_out0_valid", {31'd0, out0_valid}, 32'd1);
    in_data = 8'hB2; sel = 1'b1;
    tick();
    check("sel_out1_data", {24'd0, out1_data}, 32'hB2);
    check("sel_out1_valid", {31'd0, out1_valid}, 32'd1);
    idle(2);
    check("sel_cnt0", {24'd0, cnt0}, 32'd1);
    check("sel_cnt1", {24'd0, cnt1}, 32'd1);

    // Round-robin, back-to-back.
    mode = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1 check("rr_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (i % 2 == 1) check("rr_out0_data", {24'd0, out0_data}, 32'(i));
      else            check("rr_out1_data", {24'd0, out1_data}, 32'(i));
    end
    idle(2);
    check("rr_ptr_end", {31'd0, rr_ptr}, 32'd0);

    // Back-pressure on out0 in round-robin mode.
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10; tick();
    in_data = 8'h20; tick();
    in_data = 8'h30;
    repeat (3) begin
      #1 check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_out0_hold", {24'd0, out0_data}, 32'h10);
      tick();
    end
    out0_ready = 1'b1;
    #1 check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_out0_new", {24'd0, out0_data}, 32'h30);
    idle(3);

    // Counter wrap on out1.
    do_reset(1);
    mode = 1'b0; sel = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    idle(3);
    check("wrap_cnt1", {24'd0, cnt1}, 32'd1);

    // Reset while both slots hold beats.
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; sel = 1'b0; tick();
    in_data = 8'h66; sel = 1'b1; tick();
    in_valid = 1'b0;
    check("mid_full0", {31'd0, out0_valid}, 32'd1);
    check("mid_full1", {31'd0, out1_valid}, 32'd1);
    do_reset(1);
    check("mid_drop0", {31'd0, out0_valid}, 32'd0);
    check("mid_drop1", {31'd0, out1_valid}, 32'd0);
    check("mid_cnt1", {24'd0, cnt1}, 32'd0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      sel        = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      out0_ready = ($urandom_range(0, 9) < 7);
      out1_ready = ($urandom_range(0, 9) < 5);
      rst_n      = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;

    // Drain with a bounded budget.
    out0_ready = 1'b1; out1_ready = 1'b1;
    idle(10);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
